// File: rtl/adc_sequencer_if.sv
// Signal bundle between the ADC sequencer and its surroundings:
// slot config, ADC command/response streams, sample delivery, flags.
interface adc_sequencer_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic          run_in;
    logic [SW-1:0] cfg_slot_in;
    logic [4:0]    cfg_channel_in;
    logic          cfg_en_in;
    logic          cfg_stb_in;
    logic          cfg_ack_out;
    logic          command_valid_out;
    logic [4:0]    command_channel_out;
    logic          command_startofpacket_out;
    logic          command_endofpacket_out;
    logic          command_ready_in;
    logic          response_valid_in;
    logic [4:0]    response_channel_in;
    logic [11:0]   response_data_in;
    logic [11:0]   sample_out;
    logic [SW-1:0] sample_slot_out;
    logic          sample_stb_out;
    logic          sample_ack_in;
    logic          overflow_out;
    logic          mismatch_out;
    logic          clear_in;

    modport slave (
        input  run_in, cfg_slot_in, cfg_channel_in, cfg_en_in, cfg_stb_in,
        input  command_ready_in,
        input  response_valid_in, response_channel_in, response_data_in,
        input  sample_ack_in, clear_in,
        output cfg_ack_out,
        output command_valid_out, command_channel_out,
        output command_startofpacket_out, command_endofpacket_out,
        output sample_out, sample_slot_out, sample_stb_out,
        output overflow_out, mismatch_out
    );

    modport master (
        output run_in, cfg_slot_in, cfg_channel_in, cfg_en_in, cfg_stb_in,
        output command_ready_in,
        output response_valid_in, response_channel_in, response_data_in,
        output sample_ack_in, clear_in,
        input  cfg_ack_out,
        input  command_valid_out, command_channel_out,
        input  command_startofpacket_out, command_endofpacket_out,
        input  sample_out, sample_slot_out, sample_stb_out,
        input  overflow_out, mismatch_out
    );
endinterface

// File: rtl/adc_sequencer.sv
// Round-robin ADC conversion sequencer: issues single-beat commands from a
// slot table, tracks in-flight tags and routes matched samples to the output.
module adc_sequencer #(
    parameter int NUM_SLOTS    = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input logic             clk,
    input logic             rst_n,
    adc_sequencer_if.slave  bus
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int FW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [4:0]           slot_ch [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_en;
    logic [SW-1:0]        ptr;

    logic [SW-1:0] tag_slot [MAX_INFLIGHT];
    logic [4:0]    tag_ch   [MAX_INFLIGHT];
    logic [FW-1:0] rd_ptr;
    logic [FW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          cmd_valid;
    logic [4:0]    cmd_ch;
    logic [SW-1:0] cmd_slot;

    logic          smp_stb;
    logic [11:0]   smp;
    logic [SW-1:0] smp_slot;
    logic          ovf;
    logic          mis;

    logic          accept;
    logic          pop;
    logic          matched;
    logic          bad;
    logic          load;
    logic          drop;
    logic          can_issue;
    logic          found;
    logic [SW-1:0] pick;
    logic [SW-1:0] ptr_n;
    logic [SW-1:0] slot_inc;

    function automatic logic [FW-1:0] fifo_inc(logic [FW-1:0] p);
        return (p == FW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept   = cmd_valid & bus.command_ready_in;
    assign pop      = bus.response_valid_in & (count != '0);
    assign matched  = pop & (bus.response_channel_in == tag_ch[rd_ptr]);
    assign bad      = bus.response_valid_in & ~matched;
    assign load     = matched & (~smp_stb | bus.sample_ack_in);
    assign drop     = matched & ~load;
    assign slot_inc = (cmd_slot == SW'(NUM_SLOTS - 1)) ? '0 : cmd_slot + 1'b1;
    assign ptr_n    = accept ? slot_inc : ptr;

    // Search starts from the pointer as it will be after this cycle's accept.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            logic [SW-1:0] idx;
            idx = SW'((int'(ptr_n) + i) % NUM_SLOTS);
            if (!found && slot_en[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign can_issue = bus.run_in & found &
                       ((count + CW'(accept)) < CW'(MAX_INFLIGHT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_ch[i] <= 5'(i);
            end
            slot_en   <= '0;
            ptr       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            cmd_valid <= 1'b0;
            cmd_ch    <= '0;
            cmd_slot  <= '0;
            smp_stb   <= 1'b0;
            smp       <= '0;
            smp_slot  <= '0;
            ovf       <= 1'b0;
            mis       <= 1'b0;
        end else begin
            if (bus.cfg_stb_in) begin
                slot_ch[bus.cfg_slot_in] <= bus.cfg_channel_in;
                slot_en[bus.cfg_slot_in] <= bus.cfg_en_in;
            end
            if (accept) begin
                ptr              <= slot_inc;
                tag_slot[wr_ptr] <= cmd_slot;
                tag_ch[wr_ptr]   <= cmd_ch;
                wr_ptr           <= fifo_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= fifo_inc(rd_ptr);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A pending command is frozen until the ADC takes it.
            if (!cmd_valid || accept) begin
                cmd_valid <= can_issue;
                if (can_issue) begin
                    cmd_ch   <= slot_ch[pick];
                    cmd_slot <= pick;
                end
            end
            if (load) begin
                smp      <= bus.response_data_in;
                smp_slot <= tag_slot[rd_ptr];
                smp_stb  <= 1'b1;
            end else if (smp_stb && bus.sample_ack_in) begin
                smp_stb <= 1'b0;
            end
            ovf <= (ovf & ~bus.clear_in) | drop;
            mis <= (mis & ~bus.clear_in) | bad;
        end
    end

    assign bus.cfg_ack_out               = 1'b1;
    assign bus.command_valid_out         = cmd_valid;
    assign bus.command_channel_out       = cmd_ch;
    assign bus.command_startofpacket_out = cmd_valid;
    assign bus.command_endofpacket_out   = cmd_valid;
    assign bus.sample_out                = smp;
    assign bus.sample_slot_out           = smp_slot;
    assign bus.sample_stb_out            = smp_stb;
    assign bus.overflow_out              = ovf;
    assign bus.mismatch_out              = mis;
endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: directed scenarios then random traffic, each cycle
// predicted by a queue-based reference model and checked by a monitor.
module tb_adc_sequencer;
    localparam int NS = 4;
    localparam int MI = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_sequencer_if #(.NUM_SLOTS(NS)) bus ();

    adc_sequencer #(
        .NUM_SLOTS(NS),
        .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        bit full;
        bit cv;
        int cch;
        bit stb;
        int sd;
        int ss;
        bit ovf;
        bit mis;
    } exp_t;

    typedef struct {
        int slot;
        int ch;
    } tag_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int   m_ch[NS];
    bit   m_en[NS];
    int   m_ptr;
    tag_t tags[$];
    bit   m_cv;
    int   m_cch;
    int   m_cslot;
    bit   m_stb;
    int   m_sd;
    int   m_ss;
    bit   m_ovf;
    bit   m_mis;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("cfg_ack", 32'(bus.cfg_ack_out), 1);
            chk("cmd_valid", 32'(bus.command_valid_out), 32'(mon_e.cv));
            chk("cmd_sop", 32'(bus.command_startofpacket_out), 32'(mon_e.cv));
            chk("cmd_eop", 32'(bus.command_endofpacket_out), 32'(mon_e.cv));
            if (mon_e.cv || mon_e.full)
                chk("cmd_channel", 32'(bus.command_channel_out), mon_e.cch);
            chk("sample_stb", 32'(bus.sample_stb_out), 32'(mon_e.stb));
            if (mon_e.stb || mon_e.full) begin
                chk("sample", 32'(bus.sample_out), mon_e.sd);
                chk("sample_slot", 32'(bus.sample_slot_out), mon_e.ss);
            end
            chk("overflow", 32'(bus.overflow_out), 32'(mon_e.ovf));
            chk("mismatch", 32'(bus.mismatch_out), 32'(mon_e.mis));
        end
    end

    // Advance the model by the clock edge that consumed the current inputs.
    task automatic model_update();
        exp_t e;
        tag_t h;
        int   n0;
        int   pick;
        bit   acc;
        bit   matched;
        bit   set_ovf;
        bit   set_mis;
        e.full = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                m_ch[i] = i;
                m_en[i] = 1'b0;
            end
            m_ptr = 0;
            tags.delete();
            m_cv = 0; m_cch = 0; m_cslot = 0;
            m_stb = 0; m_sd = 0; m_ss = 0;
            m_ovf = 0; m_mis = 0;
            e.full = 1'b1;
        end else begin
            n0      = tags.size();
            acc     = m_cv && bus.command_ready_in;
            matched = 1'b0;
            set_ovf = 1'b0;
            set_mis = 1'b0;
            if (bus.response_valid_in) begin
                if (n0 == 0) begin
                    set_mis = 1'b1;
                end else begin
                    h = tags.pop_front();
                    if (h.ch == int'(bus.response_channel_in)) matched = 1'b1;
                    else set_mis = 1'b1;
                end
            end
            if (matched) begin
                if (!m_stb || bus.sample_ack_in) begin
                    m_stb = 1'b1;
                    m_sd  = int'(bus.response_data_in);
                    m_ss  = h.slot;
                end else begin
                    set_ovf = 1'b1;
                end
            end else if (m_stb && bus.sample_ack_in) begin
                m_stb = 1'b0;
            end
            m_ovf = bus.clear_in ? set_ovf : (m_ovf | set_ovf);
            m_mis = bus.clear_in ? set_mis : (m_mis | set_mis);
            if (acc) begin
                tags.push_back('{m_cslot, m_cch});
                m_ptr = (m_cslot + 1) % NS;
            end
            if (!m_cv || acc) begin
                pick = -1;
                for (int k = 0; k < NS; k++)
                    if (pick < 0 && m_en[(m_ptr + k) % NS]) pick = (m_ptr + k) % NS;
                if (bus.run_in && pick >= 0 && (n0 + int'(acc)) < MI) begin
                    m_cv    = 1'b1;
                    m_cslot = pick;
                    m_cch   = m_ch[pick];
                end else begin
                    m_cv = 1'b0;
                end
            end
            if (bus.cfg_stb_in) begin
                m_ch[bus.cfg_slot_in] = int'(bus.cfg_channel_in);
                m_en[bus.cfg_slot_in] = bus.cfg_en_in;
            end
        end
        e.cv  = m_cv;  e.cch = m_cch;
        e.stb = m_stb; e.sd  = m_sd;  e.ss = m_ss;
        e.ovf = m_ovf; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic cfg(int s, int ch, bit en);
        bus.cfg_stb_in     = 1'b1;
        bus.cfg_slot_in    = 2'(s);
        bus.cfg_channel_in = 5'(ch);
        bus.cfg_en_in      = en;
    endtask

    task automatic resp_head(logic [11:0] d);
        bus.response_valid_in   = 1'b1;
        bus.response_channel_in = (tags.size() > 0) ? 5'(tags[0].ch) : 5'd3;
        bus.response_data_in    = d;
    endtask

    task automatic quiet();
        bus.cfg_stb_in        = 1'b0;
        bus.response_valid_in = 1'b0;
        bus.clear_in          = 1'b0;
    endtask

    initial begin
        rst_n                   = 1'b0;
        bus.run_in              = 1'b0;
        bus.cfg_slot_in         = '0;
        bus.cfg_channel_in      = '0;
        bus.cfg_en_in           = 1'b0;
        bus.cfg_stb_in          = 1'b0;
        bus.command_ready_in    = 1'b0;
        bus.response_valid_in   = 1'b0;
        bus.response_channel_in = '0;
        bus.response_data_in    = '0;
        bus.sample_ack_in       = 1'b0;
        bus.clear_in            = 1'b0;
        step(); step();

        // Slots 0 and 2 on channels 3 and 7, free-running ready
        rst_n = 1'b1;
        cfg(0, 3, 1'b1); step();
        cfg(2, 7, 1'b1); step();
        quiet();
        bus.run_in = 1'b1;
        bus.command_ready_in = 1'b1;
        repeat (8) step();

        // Matched response with consumer ready, then overflow with ack low
        bus.sample_ack_in = 1'b1;
        bus.response_valid_in   = 1'b1;
        bus.response_channel_in = 5'd3;
        bus.response_data_in    = 12'hABC;
        step();
        quiet(); step();
        bus.sample_ack_in = 1'b0;
        resp_head(12'h123); step();
        resp_head(12'h456); step();
        quiet(); step();
        bus.clear_in = 1'b1; step();
        quiet(); step();

        // Wrong channel while a tag is outstanding
        bus.response_valid_in   = 1'b1;
        bus.response_channel_in = 5'd5;
        step();
        quiet();
        bus.sample_ack_in = 1'b1;
        step();

        // Stall with run dropping and the slot reconfigured underneath
        bus.command_ready_in = 1'b0;
        step();
        bus.run_in = 1'b0;
        cfg(0, 9, 1'b0); step();
        quiet();
        repeat (4) step();
        bus.command_ready_in = 1'b1;
        step(); step();
        cfg(0, 3, 1'b1); step();
        quiet();

        // Reset with commands in flight, then a stale response
        bus.run_in = 1'b1;
        repeat (4) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        bus.response_valid_in   = 1'b1;
        bus.response_channel_in = 5'd3;
        step();
        quiet(); step();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rst_n                = ($urandom_range(0, 299) != 0);
            bus.run_in           = ($urandom_range(0, 9) < 8);
            bus.command_ready_in = ($urandom_range(0, 3) != 0);
            bus.sample_ack_in    = ($urandom_range(0, 9) < 6);
            bus.clear_in         = ($urandom_range(0, 19) == 0);
            bus.cfg_stb_in       = ($urandom_range(0, 9) == 0);
            bus.cfg_slot_in      = 2'($urandom_range(0, NS - 1));
            bus.cfg_channel_in   = 5'($urandom);
            bus.cfg_en_in        = ($urandom_range(0, 3) != 0);
            bus.response_valid_in = ($urandom_range(0, 9) < 4);
            bus.response_data_in  = 12'($urandom);
            if (tags.size() > 0 && $urandom_range(0, 9) < 8)
                bus.response_channel_in = 5'(tags[0].ch);
            else
                bus.response_channel_in = 5'($urandom);
            step();
        end

        quiet();
        bus.run_in = 1'b0;
        repeat (3) step();
        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
